// File: rtl/amba_axi4_lite_slave.sv
// AXI4-Lite slave front end for a small word-indexed register core.
// Write and read channels run independently; a read that hits a word being written stalls one cycle.
//   state    | meaning
//   RD_IDLE  | ARREADY high, waiting for a read address
//   RD_ISSUE | o_rd_en pulse to the core (or stall / error bypass)
//   RD_RESP  | RVALID high until RREADY
module amba_axi4_lite_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_REGS = 5,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int SECURE_ONLY = 0,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  input  logic              i_is_busy,
  output logic              o_wr_en,
  output logic [IDX_W-1:0]  o_wr_idx,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [STRB_W-1:0] o_wr_strb,
  output logic              o_rd_en,
  output logic [IDX_W-1:0]  o_rd_idx,
  input  logic [DATA_W-1:0] i_rd_data
);

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ISSUE = 2'd1, RD_RESP = 2'd2} rd_state_t;

  localparam int AL = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] decode_resp(input logic [ADDR_W-1:0] addr, input logic ns,
                                             input logic busy);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    if ((addr < BASE_ADDR) || ((off >> AL) >= ADDR_W'(NUM_REGS))) return RESP_DECERR;
    if ((SECURE_ONLY != 0) && ns) return RESP_SLVERR;
    if (busy) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] decode_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> AL);
  endfunction

  logic              aw_full_q, aw_full_d, aw_ns_q, aw_ns_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_en_q, wr_en_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
  rd_state_t         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rd_en_q, rd_en_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        wr_resp, rd_resp;
  logic              aw_hs, w_hs, ar_hs;
  logic              unused_prot;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign ar_hs = ARVALID & arready_q;
  assign unused_prot = ^{AWPROT[2], AWPROT[0], ARPROT[2], ARPROT[0]};

  always_comb begin
    aw_full_d = aw_full_q | aw_hs;
    aw_addr_d = aw_hs ? AWADDR : aw_addr_q;
    aw_ns_d   = aw_hs ? AWPROT[1] : aw_ns_q;
    w_full_d  = w_full_q | w_hs;
    w_data_d  = w_hs ? WDATA : w_data_q;
    w_strb_d  = w_hs ? WSTRB : w_strb_q;
    bvalid_d  = bvalid_q & ~BREADY;
    bresp_d   = bresp_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    wr_resp   = decode_resp(aw_addr_d, aw_ns_d, i_is_busy);
    // Second half of the write pair arrives: issue to the core and respond in the same cycle.
    if (aw_full_d && w_full_d) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_resp;
      wr_en_d   = (wr_resp == RESP_OKAY) && (w_strb_d != '0);
      wr_idx_d  = decode_idx(aw_addr_d);
      wr_data_d = w_data_d;
      wr_strb_d = w_strb_d;
    end
    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;

    rd_state_d = rd_state_q;
    rd_en_d    = 1'b0;
    rd_idx_d   = rd_idx_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_resp    = decode_resp(ARADDR, ARPROT[1], i_is_busy);
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_ISSUE;
          rd_idx_d   = decode_idx(ARADDR);
          rresp_d    = rd_resp;
          rd_en_d    = (rd_resp == RESP_OKAY) && !(wr_en_d && (wr_idx_d == rd_idx_d));
        end
      end
      RD_ISSUE: begin
        if (rresp_q != RESP_OKAY) begin
          rdata_d    = '0;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end else if (rd_en_q) begin
          rdata_d    = i_rd_data;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end else begin
          rd_en_d = !(wr_en_d && (wr_idx_d == rd_idx_q));
        end
      end
      RD_RESP: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      aw_ns_q    <= 1'b0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      aw_ns_q    <= aw_ns_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rd_en_q    <= rd_en_d;
      rd_idx_q   <= rd_idx_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RRESP     = rresp_q;
  assign RDATA     = rdata_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_idx  = wr_idx_q;
  assign o_wr_data = wr_data_q;
  assign o_wr_strb = wr_strb_q;
  assign o_rd_en   = rd_en_q;
  assign o_rd_idx  = rd_idx_q;

endmodule
